icache: RTL and testbench

// Direct-mapped, read-only instruction cache answering the fetch stage's cache port.
// - Fetch side: takes addr_to_cache_o; returns data_from_cache_i / data_cache_valid_i.
// - On a miss: raises inst_cache_stall_i to control_flow_bubble, refills the whole line

---
 rtl/icache_pkg.sv | 35 +++
 rtl/icache_refill_ctrl.sv | 69 ++++++
 rtl/icache.sv | 185 ++++++++++++++++++
 tb/tb_icache.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and default geometry for the direct-mapped
//               instruction cache: FSM state encoding, address field widths
//               and the packed address view {tag, index, offset, byte}.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int ICACHE_ADDR_W     = 32;
    localparam int ICACHE_DATA_W     = 32;
    localparam int ICACHE_LINES      = 64;
    localparam int ICACHE_LINE_WORDS = 4;

    localparam int OFF_W = $clog2(ICACHE_LINE_WORDS);
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = ICACHE_ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        REFILL = 2'd2,
        RESP   = 2'd3
    } icache_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [OFF_W-1:0] offset;
        logic [1:0]       byte_sel;
    } icache_addr_t;

endpackage
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_refill_ctrl
// Description : Line refill sequencer. Walks a word counter from 0 to
//               LINE_WORDS-1, keeps one backing-memory read outstanding at a
//               time and flags the cycle in which the last word returns.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               i_start         - clear the word counter (miss detected)
//               i_active        - refill in progress
//               i_mem_valid     - backing-memory read data valid
//               i_line_addr     - {tag, index} of the line being filled
//               o_mem_rd        - read request
//               o_mem_addr      - word-aligned byte address of the request
//               o_cnt           - word slot to be written this cycle
//               o_last          - last word of the line returns this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    i_start,
    input  logic                                    i_active,
    input  logic                                    i_mem_valid,
    input  logic [ADDR_W-$clog2(LINE_WORDS)-3:0]    i_line_addr,
    output logic                                    o_mem_rd,
    output logic [ADDR_W-1:0]                       o_mem_addr,
    output logic [$clog2(LINE_WORDS)-1:0]           o_cnt,
    output logic                                    o_last
);

    localparam int                  c_off_w = $clog2(LINE_WORDS);
    localparam logic [c_off_w-1:0]  c_last  = c_off_w'(LINE_WORDS - 1);

    logic [c_off_w-1:0] r_cnt;
    logic [c_off_w-1:0] w_cnt_nxt;

    // Counter wraps naturally at LINE_WORDS, so it is back at 0 once the
    // line is complete.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_start) begin
            w_cnt_nxt = '0;
        end else if (i_active && i_mem_valid) begin
            w_cnt_nxt = r_cnt + c_off_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // The request stays up for the whole refill; each returned word advances
    // the counter, so the next word's request appears the following cycle.
    assign o_mem_rd   = i_active;
    assign o_mem_addr = i_active ? {i_line_addr, r_cnt, 2'b00} : '0;
    assign o_cnt      = r_cnt;
    assign o_last     = i_active && i_mem_valid && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped, read-only instruction cache. Hits return one
//               cycle after the request and may stream back-to-back; misses
//               stall fetch, refill the whole line from word 0 and then
//               return the requested word.
// Ports       : clk_i, rst_n_i  - clock, asynchronous active-low reset
//               rd_i, addr_i    - fetch request and byte address
//               inval_i         - invalidate all lines
//               data_o, valid_o - returned instruction and its strobe
//               stall_o         - miss in progress
//               mem_rd_o, mem_addr_o, mem_data_i, mem_valid_i
//                               - backing-memory word read port
// Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W     = ICACHE_ADDR_W,
    parameter int DATA_W     = ICACHE_DATA_W,
    parameter int LINES      = ICACHE_LINES,
    parameter int LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              rd_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              inval_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              stall_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_valid_i
);

    localparam int c_off_w = $clog2(LINE_WORDS);
    localparam int c_idx_w = $clog2(LINES);
    localparam int c_tag_w = ADDR_W - c_idx_w - c_off_w - 2;

    icache_state_t       r_state;
    icache_state_t       w_state_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data_hold;
    logic                r_inval_seen;
    logic [LINES-1:0]    r_valid;
    logic [DATA_W-1:0]   r_data_arr [LINES*LINE_WORDS];
    logic [c_tag_w-1:0]  r_tag_arr  [LINES];

    logic [c_off_w-1:0]  w_off;
    logic [c_idx_w-1:0]  w_idx;
    logic [c_tag_w-1:0]  w_tag;
    logic                w_hit;
    logic [DATA_W-1:0]   w_word;
    logic                w_latch;
    logic                w_start;
    logic                w_active;
    logic                w_valid;
    logic                w_stall;
    logic [c_off_w-1:0]  w_cnt;
    logic                w_last;
    logic                w_unused_byte;

    // Byte-select bits never influence a word fetch.
    assign w_unused_byte = ^r_addr[1:0];

    // All lookups and refills work from the latched address; fetch holds
    // addr_i during a stall, but the cache does not rely on it.
    assign w_off  = r_addr[2 +: c_off_w];
    assign w_idx  = r_addr[2 + c_off_w +: c_idx_w];
    assign w_tag  = r_addr[ADDR_W-1 -: c_tag_w];
    assign w_hit  = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
    assign w_word = r_data_arr[{w_idx, w_off}];

    assign w_active = (r_state == REFILL);

    icache_refill_ctrl #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_refill_ctrl (
        .clk         (clk_i),
        .rst_n       (rst_n_i),
        .i_start     (w_start),
        .i_active    (w_active),
        .i_mem_valid (mem_valid_i),
        .i_line_addr (r_addr[ADDR_W-1:c_off_w+2]),
        .o_mem_rd    (mem_rd_o),
        .o_mem_addr  (mem_addr_o),
        .o_cnt       (w_cnt),
        .o_last      (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_start     = 1'b0;
        w_valid     = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                if (w_hit) begin
                    w_valid = 1'b1;
                    // A new request in the hit cycle keeps streaming.
                    if (rd_i) begin
                        w_latch = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_stall     = 1'b1;
                    w_start     = 1'b1;
                    w_state_nxt = REFILL;
                end
            end
            REFILL: begin
                w_stall = 1'b1;
                if (w_last) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_valid     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign valid_o = w_valid;
    assign stall_o = w_stall;
    // data_o is held from the last returned word whenever valid_o is low.
    assign data_o  = w_valid ? w_word : r_data_hold;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_data_hold  <= '0;
            r_inval_seen <= 1'b0;
            r_valid      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_data_hold <= data_o;
            if (w_latch) begin
                r_addr <= addr_i;
            end
            // Remember an invalidate that lands while the line is being
            // filled, so the filled line is not published as valid.
            if (w_start) begin
                r_inval_seen <= 1'b0;
            end else if (w_active && inval_i) begin
                r_inval_seen <= 1'b1;
            end
            // Invalidate takes priority over marking the new line valid.
            if (inval_i) begin
                r_valid <= '0;
            end else if (w_last && !r_inval_seen) begin
                r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Data and tag storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk_i) begin
        if (w_active && mem_valid_i) begin
            r_data_arr[{w_idx, w_cnt}] <= mem_data_i;
        end
        if (w_last) begin
            r_tag_arr[w_idx] <= w_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Directed self-checking bench for icache with a fixed-latency
//               backing-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;
    import icache_pkg::*;

    localparam int LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        rd_i;
    logic [31:0] addr_i;
    logic        inval_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        stall_o;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_i;
    logic        mem_valid_i;

    int          checks = 0;
    int          errors = 0;
    int          wait_cnt = 0;
    int          mem_rd_cycles = 0;
    logic        stray = 1'b0;
    logic [31:0] mem_q[$];

    always #5 clk_i = ~clk_i;

    icache dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .rd_i        (rd_i),
        .addr_i      (addr_i),
        .inval_i     (inval_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .stall_o     (stall_o),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_i  (mem_data_i),
        .mem_valid_i (mem_valid_i)
    );

    // Memory image: line 0x100 holds 0xA0..0xA3, other lines differ in the
    // upper bits so a wrong line is visible in the returned word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [27:0] hi;
        hi = a[31:4] ^ 28'h010;
        return {hi[23:0], 8'hA0 + {6'd0, a[3:2]}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Backing memory: answers each request LAT cycles after it appears.
    initial begin
        mem_valid_i = 1'b0;
        mem_data_i  = '0;
        forever begin
            @(negedge clk_i);
            if (mem_valid_i) begin
                mem_valid_i = 1'b0;
                wait_cnt    = 0;
            end
            if (stray) begin
                stray       = 1'b0;
                mem_valid_i = 1'b1;
                mem_data_i  = 32'hDEADBEEF;
            end else if (mem_rd_o) begin
                mem_rd_cycles++;
                wait_cnt++;
                if (wait_cnt == LAT) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = mem_word(mem_addr_o);
                    mem_q.push_back(mem_addr_o);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic fetch_miss(input string name, input logic [31:0] a,
                              input logic [31:0] exp, input int inval_at);
        int stalls;
        bit got;
        mem_q.delete();
        rd_i   = 1'b1;
        addr_i = a;
        @(negedge clk_i);
        chk({name, " lookup stall"}, 32'(stall_o), 32'd1);
        chk({name, " lookup valid"}, 32'(valid_o), 32'd0);
        stalls = 1;
        got    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            inval_i = (i == inval_at);
            if (valid_o) begin
                got = 1'b1;
                break;
            end
            if (stall_o) stalls++;
        end
        inval_i = 1'b0;
        chk({name, " resp seen"}, 32'(got), 32'd1);
        chk({name, " resp data"}, data_o, exp);
        chk({name, " resp stall"}, 32'(stall_o), 32'd0);
        chk({name, " stall cycles"}, 32'(stalls), 32'(1 + 4 * LAT));
        chk({name, " mem reads"}, 32'(mem_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < mem_q.size(); k++) begin
            chk($sformatf("%s mem addr %0d", name, k), mem_q[k], (a & ~32'hF) + 32'(4 * k));
        end
        rd_i = 1'b0;
        @(negedge clk_i);
        chk({name, " valid drop"}, 32'(valid_o), 32'd0);
        chk({name, " data hold"}, data_o, exp);
    endtask

    task automatic fetch_hit(input string name, input logic [31:0] a, input logic [31:0] exp);
        rd_i   = 1'b1;
        addr_i = a;
        @(negedge clk_i);
        chk({name, " valid"}, 32'(valid_o), 32'd1);
        chk({name, " data"}, data_o, exp);
        chk({name, " stall"}, 32'(stall_o), 32'd0);
        rd_i = 1'b0;
        @(negedge clk_i);
        chk({name, " valid drop"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        int rd_before;
        rst_n_i = 1'b0;
        rd_i    = 1'b0;
        addr_i  = '0;
        inval_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("reset data_o", data_o, 32'h0);
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset stall_o", 32'(stall_o), 32'd0);
        chk("reset mem_rd_o", 32'(mem_rd_o), 32'd0);
        chk("reset mem_addr_o", mem_addr_o, 32'h0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Cold miss
        fetch_miss("cold 0x100", 32'h100, 32'hA0, -1);

        // Back-to-back hits
        rd_before = mem_rd_cycles;
        rd_i   = 1'b1;
        addr_i = 32'h104;
        @(negedge clk_i);
        chk("b2b 0x104 valid", 32'(valid_o), 32'd1);
        chk("b2b 0x104 data", data_o, 32'hA1);
        addr_i = 32'h108;
        @(negedge clk_i);
        chk("b2b 0x108 valid", 32'(valid_o), 32'd1);
        chk("b2b 0x108 data", data_o, 32'hA2);
        chk("b2b 0x108 stall", 32'(stall_o), 32'd0);
        addr_i = 32'h10C;
        @(negedge clk_i);
        chk("b2b 0x10C valid", 32'(valid_o), 32'd1);
        chk("b2b 0x10C data", data_o, 32'hA3);
        rd_i = 1'b0;
        @(negedge clk_i);
        chk("b2b end valid", 32'(valid_o), 32'd0);
        chk("b2b no mem reads", 32'(mem_rd_cycles - rd_before), 32'd0);
        fetch_hit("hit 0x100", 32'h100, 32'hA0);

        // Conflict on the same index
        fetch_miss("conflict 0x500", 32'h500, 32'h40A0, -1);
        fetch_miss("reread 0x100", 32'h100, 32'hA0, -1);

        // Invalidate during a refill
        fetch_miss("inval mid 0x200", 32'h200, 32'h30A0, 3);
        fetch_miss("after inval 0x200", 32'h200, 32'h30A0, -1);
        fetch_miss("after inval 0x100", 32'h100, 32'hA0, -1);
        fetch_hit("hit 0x204", 32'h204, 32'h30A1);

        // Invalidate together with the last-word write
        fetch_miss("inval last 0x300", 32'h300, 32'h20A0, 7);
        fetch_miss("after last inval 0x300", 32'h300, 32'h20A0, -1);

        // Asynchronous reset in the middle of word 2
        rd_i   = 1'b1;
        addr_i = 32'h600;
        @(negedge clk_i);
        repeat (5) @(negedge clk_i);
        chk("pre-reset mem_addr word2", mem_addr_o, 32'h608);
        rst_n_i = 1'b0;
        rd_i    = 1'b0;
        #1;
        chk("async reset data_o", data_o, 32'h0);
        chk("async reset valid_o", 32'(valid_o), 32'd0);
        chk("async reset stall_o", 32'(stall_o), 32'd0);
        chk("async reset mem_rd_o", 32'(mem_rd_o), 32'd0);
        chk("async reset mem_addr_o", mem_addr_o, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        fetch_miss("post-reset 0x600", 32'h600, 32'h70A0, -1);

        // Stray memory response while idle
        fetch_hit("pre-stray 0x604", 32'h604, 32'h70A1);
        stray = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("stray valid_o", 32'(valid_o), 32'd0);
        end
        fetch_hit("post-stray 0x600", 32'h600, 32'h70A0);
        fetch_hit("post-stray 0x608", 32'h608, 32'h70A2);
        fetch_miss("post-stray miss 0x100", 32'h100, 32'hA0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
